// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default geometry for the
// ALU and the request scheduler that feeds it.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_RST = 2'b00,
        OP_SHL = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    localparam int DEF_DATAW   = 4;
    localparam int DEF_ALU_LAT = 2;

endpackage

// File: rtl/alu.sv
// Pipelined ALU: operands are sampled into an input register, then the result
// travels through ALU_LAT registers before reaching o_result.
module alu
    import alu_pkg::*;
#(
    parameter int DATAW   = DEF_DATAW,
    parameter int ALU_LAT = DEF_ALU_LAT
)(
    input  logic               clk,
    input  logic               rst,
    input  alu_op_e            i_op,
    input  logic [DATAW-1:0]   i_a,
    input  logic [DATAW-1:0]   i_b,
    output logic [2*DATAW-1:0] o_result
);

    localparam int RW = 2 * DATAW;

    alu_op_e          op_reg;
    logic [DATAW-1:0] a_reg;
    logic [DATAW-1:0] b_reg;
    logic [RW-1:0]    res_next;
    logic [RW-1:0]    res_reg [ALU_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg <= OP_RST;
            a_reg  <= '0;
            b_reg  <= '0;
        end else begin
            op_reg <= i_op;
            a_reg  <= i_a;
            b_reg  <= i_b;
        end
    end

    // SHL works on the zero-extended operand; ADD/SUB on sign-extended ones.
    always_comb begin
        res_next = '0;
        case (op_reg)
            OP_SHL:  res_next = {{DATAW{1'b0}}, a_reg} << b_reg;
            OP_ADD:  res_next = {{DATAW{a_reg[DATAW-1]}}, a_reg} + {{DATAW{b_reg[DATAW-1]}}, b_reg};
            OP_SUB:  res_next = {{DATAW{a_reg[DATAW-1]}}, a_reg} - {{DATAW{b_reg[DATAW-1]}}, b_reg};
            default: res_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ALU_LAT; i++) begin
                res_reg[i] <= '0;
            end
        end else begin
            res_reg[0] <= res_next;
            for (int i = 1; i < ALU_LAT; i++) begin
                res_reg[i] <= res_reg[i-1];
            end
        end
    end

    assign o_result = res_reg[ALU_LAT-1];

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one pipelined ALU among NUM_REQ requesters,
// with a tag pipeline returning each result to its owner in acceptance order.
module alu_sched
    import alu_pkg::*;
#(
    parameter int DATAW   = DEF_DATAW,
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = DEF_ALU_LAT,
    localparam int IDW    = $clog2(NUM_REQ),
    localparam int RW     = 2 * DATAW
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ-1:0][DATAW-1:0]   i_req_dataa,
    input  logic [NUM_REQ-1:0][DATAW-1:0]   i_req_datab,
    input  logic [NUM_REQ-1:0][1:0]         i_req_op,
    input  logic [NUM_REQ-1:0]              i_req_mask,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic                            o_rsp_valid,
    output logic [IDW-1:0]                  o_rsp_id,
    output logic [RW-1:0]                   o_rsp_result,
    output logic                            o_busy,
    output logic [15:0]                     o_issue_cnt
);

    logic [IDW-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] eligible;
    logic             grant_vld;
    logic [IDW-1:0]   grant_id;
    logic [IDW:0]     idx;

    logic             issue_vld_reg;
    logic [IDW-1:0]   issue_id_reg;
    alu_op_e          issue_op_reg;
    logic [DATAW-1:0] issue_a_reg;
    logic [DATAW-1:0] issue_b_reg;

    logic             tag_vld_reg [ALU_LAT+1];
    logic [IDW-1:0]   tag_id_reg  [ALU_LAT+1];
    logic [15:0]      cnt_reg;
    logic [RW-1:0]    alu_result;
    logic             busy;

    assign eligible = i_req_valid & i_req_mask;

    // Search upward from the pointer, wrapping at NUM_REQ-1.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_reg} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!grant_vld && eligible[idx[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = idx[IDW-1:0];
            end
        end
        if (rst) begin
            grant_vld = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign o_req_ready[gi] = grant_vld && (grant_id == IDW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            issue_vld_reg <= 1'b0;
            issue_id_reg  <= '0;
            issue_op_reg  <= OP_RST;
            issue_a_reg   <= '0;
            issue_b_reg   <= '0;
            cnt_reg       <= '0;
        end else if (grant_vld) begin
            ptr_reg       <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            issue_vld_reg <= 1'b1;
            issue_id_reg  <= grant_id;
            issue_op_reg  <= alu_op_e'(i_req_op[grant_id]);
            issue_a_reg   <= i_req_dataa[grant_id];
            issue_b_reg   <= i_req_datab[grant_id];
            if (cnt_reg != 16'hFFFF) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end else begin
            issue_vld_reg <= 1'b0;
            issue_id_reg  <= '0;
            issue_op_reg  <= OP_RST;
            issue_a_reg   <= '0;
            issue_b_reg   <= '0;
        end
    end

    alu #(
        .DATAW   (DATAW),
        .ALU_LAT (ALU_LAT)
    ) u_alu (
        .clk      (clk),
        .rst      (rst),
        .i_op     (issue_op_reg),
        .i_a      (issue_a_reg),
        .i_b      (issue_b_reg),
        .o_result (alu_result)
    );

    // Tag stage 0 aligns with the ALU input register; the last stage with o_result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_vld_reg[i] <= 1'b0;
                tag_id_reg[i]  <= '0;
            end
        end else begin
            tag_vld_reg[0] <= issue_vld_reg;
            tag_id_reg[0]  <= issue_id_reg;
            for (int i = 1; i <= ALU_LAT; i++) begin
                tag_vld_reg[i] <= tag_vld_reg[i-1];
                tag_id_reg[i]  <= tag_id_reg[i-1];
            end
        end
    end

    // The issue register is included so busy covers the cycle right after acceptance.
    always_comb begin
        busy = issue_vld_reg;
        for (int i = 0; i <= ALU_LAT; i++) begin
            busy = busy | tag_vld_reg[i];
        end
    end

    assign o_busy       = busy;
    assign o_rsp_valid  = tag_vld_reg[ALU_LAT];
    assign o_rsp_id     = tag_id_reg[ALU_LAT];
    assign o_rsp_result = tag_vld_reg[ALU_LAT] ? alu_result : '0;
    assign o_issue_cnt  = cnt_reg;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: table-driven single requests, directed
// arbitration/reset sequences and randomized traffic against a reference model.
module tb_alu_sched;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int RW  = 8;
    localparam int LAT = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       valid = '0;
    logic [N-1:0]       mask = '1;
    logic [N-1:0][DW-1:0] da = '0;
    logic [N-1:0][DW-1:0] db = '0;
    logic [N-1:0][1:0]  op = '0;

    logic [N-1:0]       o_req_ready;
    logic               o_rsp_valid;
    logic [1:0]         o_rsp_id;
    logic [RW-1:0]      o_rsp_result;
    logic               o_busy;
    logic [15:0]        o_issue_cnt;

    alu_sched dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (valid),
        .i_req_dataa  (da),
        .i_req_datab  (db),
        .i_req_op     (op),
        .i_req_mask   (mask),
        .o_req_ready  (o_req_ready),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_result (o_rsp_result),
        .o_busy       (o_busy),
        .o_issue_cnt  (o_issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] res;
        int         due;
    } exp_t;

    typedef struct {
        int         req;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   last_acc = 0;
    int   last_cyc = 0;
    bit   last_v = 0;
    int   last_id = 0;
    logic [7:0] last_res = '0;

    // Reference ALU from the arithmetic definition, on plain integers.
    function automatic logic [7:0] ref_alu(logic [1:0] o, logic [3:0] a, logic [3:0] b);
        int sa, sb, r;
        logic [31:0] t;
        sa = int'(a) - (a[3] ? 16 : 0);
        sb = int'(b) - (b[3] ? 16 : 0);
        case (o)
            2'b01:   r = int'(a) << int'(b);
            2'b10:   r = sa + sb;
            2'b11:   r = sa - sb;
            default: r = 0;
        endcase
        t = r;
        return t[7:0];
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, update the model at the rising edge.
    task automatic tick();
        int gid;
        logic [N-1:0] elig;
        logic [N-1:0] exp_ready;
        bit ev;
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_cnt = 0;
        end
        elig = valid & mask;
        gid = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (gid < 0 && elig[idx]) gid = idx;
        end
        if (rst) gid = -1;
        exp_ready = '0;
        if (gid >= 0) exp_ready[gid] = 1'b1;
        cmp("ready", 32'(o_req_ready), 32'(exp_ready));
        cmp("busy", 32'(o_busy), 32'(q.size() > 0));
        cmp("issue_cnt", 32'(o_issue_cnt), 32'(m_cnt));
        ev = (q.size() > 0) && (q[0].due == cyc);
        cmp("rsp_valid", 32'(o_rsp_valid), 32'(ev));
        if (ev) begin
            e = q.pop_front();
            cmp("rsp_id", 32'(o_rsp_id), 32'(e.id));
            cmp("rsp_result", 32'(o_rsp_result), 32'(e.res));
            $display("cycle %0d: response id=%0d result=%02h (expected id=%0d result=%02h)",
                     cyc, o_rsp_id, o_rsp_result, e.id, e.res);
        end else if (q.size() == 0) begin
            cmp("idle_result", 32'(o_rsp_result), 32'd0);
        end
        last_v   = o_rsp_valid;
        last_id  = int'(o_rsp_id);
        last_res = o_rsp_result;
        last_cyc = cyc;
        @(posedge clk);
        cyc++;
        if (!rst && gid >= 0) begin
            q.push_back('{id: gid, res: ref_alu(op[gid], da[gid], db[gid]), due: cyc + LAT + 1});
            m_ptr = (gid + 1) % N;
            if (m_cnt < 65535) m_cnt++;
            last_acc = cyc;
        end
        #1;
    endtask

    task automatic drain(int n);
        valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    vec_t tab[9];

    initial begin
        tab[0] = '{req: 1, op: 2'b10, a: 4'b0011, b: 4'b0010, res: 8'h05};
        tab[1] = '{req: 0, op: 2'b11, a: 4'b0010, b: 4'b0101, res: 8'hFD};
        tab[2] = '{req: 0, op: 2'b01, a: 4'b1111, b: 4'b0011, res: 8'h78};
        tab[3] = '{req: 2, op: 2'b00, a: 4'b1010, b: 4'b0101, res: 8'h00};
        tab[4] = '{req: 3, op: 2'b10, a: 4'b0111, b: 4'b0001, res: 8'h08};
        tab[5] = '{req: 3, op: 2'b11, a: 4'b1000, b: 4'b0001, res: 8'hF7};
        tab[6] = '{req: 2, op: 2'b01, a: 4'b0001, b: 4'b0111, res: 8'h80};
        tab[7] = '{req: 1, op: 2'b01, a: 4'b0101, b: 4'b1000, res: 8'h00};
        tab[8] = '{req: 0, op: 2'b10, a: 4'b1111, b: 4'b1111, res: 8'hFE};

        // Reset state.
        rst = 1'b1;
        valid = '1;
        tick();
        tick();
        valid = '0;
        rst = 1'b0;
        tick();

        // Single-request table: latency, id and result against hand-computed values.
        for (int v = 0; v < 9; v++) begin
            int ca, cnt0;
            bit seen;
            cnt0 = m_cnt;
            mask = '1;
            valid = '0;
            valid[tab[v].req] = 1'b1;
            op[tab[v].req] = tab[v].op;
            da[tab[v].req] = tab[v].a;
            db[tab[v].req] = tab[v].b;
            tick();
            ca = last_acc;
            valid = '0;
            seen = 0;
            for (int w = 0; w < 8 && !seen; w++) begin
                tick();
                if (last_v) begin
                    seen = 1;
                    cmp("tab_latency", 32'(last_cyc - ca), 32'(LAT + 1));
                    cmp("tab_id", 32'(last_id), 32'(tab[v].req));
                    cmp("tab_result", 32'(last_res), 32'(tab[v].res));
                end
            end
            if (!seen) cmp("tab_timeout", 32'd0, 32'd1);
            cmp("tab_cnt_step", 32'(m_cnt - cnt0), 32'd1);
            drain(2);
        end

        // Back-to-back requests from requester 0: SUB then SHL.
        valid = 4'b0001;
        op[0] = 2'b11; da[0] = 4'b0010; db[0] = 4'b0101;
        tick();
        op[0] = 2'b01; da[0] = 4'b1111; db[0] = 4'b0011;
        tick();
        drain(6);

        // All requesters continuously valid, full mask, then requester 2 masked.
        for (int k = 0; k < N; k++) begin
            op[k] = 2'($urandom_range(0, 3));
            da[k] = 4'($urandom);
            db[k] = 4'($urandom);
        end
        valid = '1;
        mask = '1;
        for (int i = 0; i < 12; i++) tick();
        mask = 4'b1011;
        for (int i = 0; i < 12; i++) tick();
        mask = '1;
        for (int i = 0; i < 6; i++) tick();
        drain(6);

        // Reset with two requests in flight, then restart from requester 0.
        valid = '1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        drain(6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            valid = N'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            for (int k = 0; k < N; k++) begin
                op[k] = 2'($urandom_range(0, 3));
                da[k] = 4'($urandom);
                db[k] = 4'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
        end
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter DATAW, default 4: ALU operand width; result width is 2*DATAW.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-003 Parameter ALU_LAT, default 2: ALU cycles from input sample to registered o_result.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 i_req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 i_req_dataa  input  NUM_REQ x DATAW  per-requester operand A.
REQ-008 i_req_datab  input  NUM_REQ x DATAW  per-requester operand B.
REQ-009 i_req_op  input  NUM_REQ x 2  per-requester opcode: 00 RST, 01 SHL, 10 ADD, 11 SUB.
REQ-010 i_req_mask  input  NUM_REQ  1 = requester eligible; 0 = requester never granted.
REQ-011 o_req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer = valid & ready at rising edge.
REQ-012 o_rsp_valid  output  1  response valid, one-cycle pulse per accepted request.
REQ-013 o_rsp_id  output  clog2(NUM_REQ)  index of requester owning the response.
REQ-014 o_rsp_result  output  2*DATAW  ALU result for that request.
REQ-015 o_busy  output  1  high while any accepted request has no response yet.
REQ-016 o_issue_cnt  output  16  count of accepted requests, saturates at 16'hFFFF.

Function
REQ-017 o_req_ready SHALL be combinational from i_req_valid, i_req_mask and the round-robin pointer; at most one bit set per cycle.
REQ-018 Grant SHALL go to the first requester with valid & mask, searching upward from the pointer and wrapping NUM_REQ-1 -> 0.
REQ-019 On transfer from requester k, the pointer SHALL become (k+1) mod NUM_REQ; with no transfer it holds.
REQ-020 A lone requester with continuous valid SHALL be granted every cycle (no bubbles).
REQ-021 Accepted dataa/datab/op/id SHALL be captured in an issue register at the acceptance edge and driven to the ALU the following cycle.
REQ-022 With no acceptance, the issue register SHALL drive op 00 (RST) with zero operands and an invalid tag.
REQ-023 A tag pipeline (valid + id), depth ALU_LAT+1, SHALL track each request; o_rsp_valid/o_rsp_id SHALL appear exactly ALU_LAT+1 cycles after the acceptance edge, aligned with o_rsp_result.
REQ-024 Responses SHALL return in acceptance order; there is no response backpressure.
REQ-025 o_rsp_result SHALL equal: RST -> 0; SHL -> zero-extended A << B; ADD/SUB -> sign-extended A +/- sign-extended B, in 2*DATAW bits.
REQ-026 Opcode 00 requests SHALL be accepted and answered like any other (result 0).
REQ-027 o_busy SHALL be the OR of the tag-pipeline valid bits.
REQ-028 o_issue_cnt SHALL increment by 1 per acceptance, holding at 16'hFFFF.
REQ-029 Deasserting i_req_mask[k] SHALL block new grants to k only; k's in-flight responses still return.

Reset
REQ-030 While rst is high: o_req_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_busy=0, o_issue_cnt=0, pointer=0, issue register=RST/zero/invalid.
REQ-031 Reset mid-operation SHALL clear all tags; no o_rsp_valid pulse for requests accepted before reset.
REQ-032 o_rsp_result SHALL be forced to 0 while no tag is valid, masking stale ALU pipeline contents.

Structure
REQ-033 Shared package alu_pkg SHALL hold the opcode enum (OP_RST, OP_SHL, OP_ADD, OP_SUB) and the default DATAW and ALU_LAT constants.
REQ-034 The single sub-module SHALL be the existing alu, instantiated once; arbitration and tag logic stay inline.

Verification
REQ-035 Req 1 only, ADD A=0011 B=0010 -> o_rsp_valid 3 cycles after acceptance, id=1, result 8'h05.
REQ-036 Req 0 SUB A=0010 B=0101, then req 0 SHL A=1111 B=0011 back-to-back -> results 8'hFD then 8'h78 on consecutive cycles.
REQ-037 All four requesters valid continuously, mask=1111 -> grants 0,1,2,3,0,...; response ids in same order, one per cycle.
REQ-038 mask=1011 with all valid -> requester 2 never ready; grants cycle 0,1,3; requester 2 granted first cycle after mask restored, if pointer reaches it.
REQ-039 rst asserted with two requests in flight -> outputs zero immediately, no response pulses afterwards; after release, requester 0 granted first.
REQ-040 Opcode 00 request A=1010 B=0101 -> response with result 8'h00; o_issue_cnt increments by 1.
